// File: rtl/serial_byte_loader8bit_pkg.sv
// rtl/serial_byte_loader8bit_pkg.sv - state type, widths and counter helpers for the serial byte loader
package serial_byte_loader8bit_pkg;

`include "serial_byte_loader8bit_defs.vh"

  localparam int CNT_W                = `SBL8_CNT_W;
  localparam int BITN_W               = 3;
  localparam int CLKS_PER_BIT_DEFAULT = `SBL8_CLKS_PER_BIT;

  typedef enum logic [2:0] {
    ST_IDLE  = `SBL8_ST_IDLE,
    ST_START = `SBL8_ST_START,
    ST_DATA  = `SBL8_ST_DATA,
    ST_STOP  = `SBL8_ST_STOP,
    ST_LOAD  = `SBL8_ST_LOAD,
    ST_ERR   = `SBL8_ST_ERR,
    ST_BREAK = `SBL8_ST_BREAK
  } state_t;

  // Terminal value of a counter that must span 'clks' cycles starting from 0.
  function automatic logic [CNT_W-1:0] cnt_last(input int clks);
    return CNT_W'(clks - 1);
  endfunction

endpackage

// File: rtl/serial_byte_loader8bit_if.sv
// rtl/serial_byte_loader8bit_if.sv - serial line in, register-load bus out
interface serial_byte_loader8bit_if;

  logic       RxD;
  logic [7:0] Data;
  logic       Enbar;
  logic       FrameErr;
  logic       Busy;

  // The loader samples the line and drives the register-side signals.
  modport master (
    input  RxD,
    output Data,
    output Enbar,
    output FrameErr,
    output Busy
  );

  // Line driver and downstream register side.
  modport slave (
    output RxD,
    input  Data,
    input  Enbar,
    input  FrameErr,
    input  Busy
  );

endinterface

// File: rtl/serial_byte_loader8bit_defs.vh
// rtl/serial_byte_loader8bit_defs.vh - shared state encoding, default bit period and counter width
`ifndef SERIAL_BYTE_LOADER8BIT_DEFS_VH
`define SERIAL_BYTE_LOADER8BIT_DEFS_VH

`define SBL8_ST_IDLE   3'd0
`define SBL8_ST_START  3'd1
`define SBL8_ST_DATA   3'd2
`define SBL8_ST_STOP   3'd3
`define SBL8_ST_LOAD   3'd4
`define SBL8_ST_ERR    3'd5
`define SBL8_ST_BREAK  3'd6

`define SBL8_CLKS_PER_BIT 16
`define SBL8_CNT_W        8

`endif

// File: rtl/serial_byte_loader8bit_sync2_neg.sv
// rtl/serial_byte_loader8bit_sync2_neg.sv - two-flop falling-edge synchronizer, presets to 1 on reset
module sync2_neg (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture on the falling edge; reset presets both stages to the idle-high level.
  always_ff @(negedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_byte_loader8bit.sv
// rtl/serial_byte_loader8bit.sv - async serial receiver that loads good bytes into an 8-bit register
`include "serial_byte_loader8bit_defs.vh"

module serial_byte_loader8bit
  import serial_byte_loader8bit_pkg::*;
#(
  parameter int CLKS_PER_BIT = `SBL8_CLKS_PER_BIT
) (
  input  logic                            Clk,
  input  logic                            Rst,
  serial_byte_loader8bit_if.master        bus
);

  // Start bit is re-checked at its midpoint; every later bit is sampled one full period on.
  localparam logic [CNT_W-1:0] HALF_LAST = cnt_last(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_LAST = cnt_last(CLKS_PER_BIT);

  logic              rx_s;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BITN_W-1:0] bitn_q, bitn_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        data_q, data_d;
  logic              enbar_q, enbar_d;
  logic              ferr_q, ferr_d;

  sync2_neg u_sync (
    .clk (Clk),
    .rst (Rst),
    .d   (bus.RxD),
    .q   (rx_s)
  );

  // State, counters, assembly register and registered outputs; reset overrides every transition.
  always_ff @(negedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shreg_q <= '0;
      data_q  <= 8'h00;
      enbar_q <= 1'b1;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      enbar_q <= enbar_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state and next-output decode; strobes are set on the transition into LOAD/ERR so they
  // are registered and last exactly the one cycle spent in that state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    enbar_d = 1'b1;
    ferr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
            bitn_d  = '0;
          end else begin
            // Line went back high before mid-start: treat as noise.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (cnt_q == FULL_LAST) begin
          shreg_d[bitn_q] = rx_s;
          cnt_d           = '0;
          bitn_d          = bitn_q + 1'b1;
          if (bitn_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_LOAD;
            data_d  = shreg_q;
            enbar_d = 1'b0;
          end else begin
            state_d = ST_ERR;
            ferr_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Single strobe cycle; IDLE is re-entered immediately so a back-to-back start is caught.
      ST_LOAD: begin
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        state_d = ST_BREAK;
      end

      // Hold off until the line is released so a held-low break never decodes as frames.
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.Data     = data_q;
  assign bus.Enbar    = enbar_q;
  assign bus.FrameErr = ferr_q;
  assign bus.Busy     = (state_q != ST_IDLE);

endmodule

// File: doc/serial_byte_loader8bit.md
# serial_byte_loader8bit

Asynchronous-serial receiver that writes into an 8-bit load-enabled register. It samples an idle-high serial line framed as start(0), 8 data bits LSB first, stop(1), and assembles each byte. On a good frame it presents the byte on `Data` and drives an active-low, one-cycle `Enbar` strobe, ready to connect directly to the register's `in`/`Enbar` ports. A bad stop bit raises `FrameErr`, and the register is not written.

## Interface
- `CLKS_PER_BIT`, default 16: `Clk` cycles per serial bit period; legal range 4..256.
- `Clk`  input  1  clock; every flop in the block updates on the falling edge.
- `Rst`  input  1  synchronous, active-high reset, sampled on the falling edge of `Clk`.
- `RxD`  input  1  serial line, asynchronous to `Clk`, idle high.
- `Data`  output  8  last correctly received byte.
- `Enbar`  output  1  active-low load strobe for the downstream register.
- `FrameErr`  output  1  one-cycle pulse when the stop bit is sampled as 0.
- `Busy`  output  1  high in every state except IDLE.

## Operation
- **Input synchronizer:** `RxD` passes through a 2-flop synchronizer. Its output is `rx_s`. Both flops reset to 1.
- **Counters:**
  - `cnt` is an 8-bit bit-period counter.
  - `bitn` is a 3-bit data-bit index.
  - `shreg` is an 8-bit assembly register, separate from `Data`.
- **States:** IDLE, START, DATA, STOP, LOAD, ERR, BREAK. The encoding is 3-bit binary.
- **IDLE:** if `rx_s`=0, go to START with `cnt`=0.
- **START:** `cnt` increments. At `cnt`=`CLKS_PER_BIT`/2−1 (integer division), check `rx_s`:
  - `rx_s`=0: go to DATA with `cnt`=0 and `bitn`=0.
  - `rx_s`=1: this is a glitch; return to IDLE with no output activity.
- **DATA:** at `cnt`=`CLKS_PER_BIT`−1:
  - store `shreg[bitn]`←`rx_s`, set `cnt`=0, increment `bitn`;
  - after the sample with `bitn`=7, go to STOP.
- **STOP:** at `cnt`=`CLKS_PER_BIT`−1, check `rx_s`:
  - `rx_s`=1: go to LOAD.
  - `rx_s`=0: go to ERR.
- **LOAD:** on entry, `Data`←`shreg`. `Enbar`=0 for exactly this one cycle, then go to IDLE.
- **ERR:** `FrameErr`=1 for this one cycle. `Data` and `Enbar` are untouched. Then go to BREAK.
- **BREAK:** wait until `rx_s`=1, then go to IDLE. A held-low (break) line therefore never produces spurious frames.
- **`Data` retention:** `Data` changes only on entry to LOAD and is stable while `Enbar`=0 and afterwards.
- **Back-to-back frames:** a new start bit detected in the cycle after LOAD is accepted; there is no dead time beyond the LOAD cycle.
- **Reset values (`Rst`=1):** state IDLE, `Data`=8'h00, `Enbar`=1, `FrameErr`=0, `Busy`=0, `shreg`=0, `cnt`=0, `bitn`=0.
- **Reset mid-frame:** reset has priority over every transition. A partial frame is discarded and produces no strobe.
- **Simultaneous `Rst` and LOAD entry:** reset wins, so `Enbar` stays 1 and `Data` stays 8'h00.

## Timing
- `rx_s` lags `RxD` by 2 cycles.
- Take cycle t as the first cycle in which `rx_s`=0 while in IDLE. Then:
  - START lasts t+1..t+8 for `CLKS_PER_BIT`=16, with the start check at t+8;
  - data bit k is sampled at t+24+16k;
  - the stop bit is sampled at t+152;
  - `Enbar`=0 during cycle t+153.
- General latency from the `RxD` falling edge to `Enbar` low: 2 + 1 + `CLKS_PER_BIT`/2 + 9·`CLKS_PER_BIT` cycles.
- Outputs launch on a falling edge. A register clocked on the same `Clk` falling edge captures `Data` at the edge that ends the LOAD cycle.
- `FrameErr` has the same timing as `Enbar` would have had for that frame.

## Structure
- Shared include header, `serial_byte_loader8bit_defs.vh`, with an include guard. It holds:
  - the state encoding defines;
  - the default `CLKS_PER_BIT`;
  - the counter width (8).
- Sub-module `sync2_neg`: 2-flop falling-edge synchronizer with a synchronous preset-to-1 reset. The FSM, counters, `shreg` and output registers live in the top module.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- **Reset:** hold `Rst` for 3 cycles with `RxD`=1 → `Data`=8'h00, `Enbar`=1, `FrameErr`=0, `Busy`=0.
- **Single frame:** send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) → `Enbar`=0 for exactly 1 cycle, 155 cycles after the `RxD` falling edge. `Data`=8'hA5 is captured by the attached 8-bit register.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap → two `Enbar` pulses 160 cycles apart. `Data` reads 8'h00, then 8'hFF.
- **Glitch:** drive `RxD` low for 4 cycles in IDLE → back to IDLE with no `Enbar` and no `FrameErr`; `Busy` is high for ≤8 cycles.
- **Framing error:** send 0x3C with stop bit 0, then hold `RxD` low for 40 cycles → one `FrameErr` pulse, no `Enbar`, `Data` keeps its prior value, `Busy` stays high until `rx_s` returns to 1.
- **Reset mid-frame:** assert `Rst` during data bit 4 of a 0x5A frame, then send 0xC3 → no strobe for 0x5A. `Data`=8'hC3 after the next `Enbar`.
